// File: rtl/fu_alu_pipe.sv
`timescale 1ns / 1ps
// fu_alu_pipe: issue-side operand stage feeding an external combinational ALU,
// followed by a small in-order result FIFO with a valid/ready writeback port.
// Also keeps a saturating count of overflowing results that were written back.
module fu_alu_pipe #(
  parameter int unsigned TAG_W = 4,
  parameter int unsigned DEPTH = 2   // power of two, >= 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  // issue
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_aluop,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [4:0]       in_rd,
  input  logic [TAG_W-1:0] in_tag,
  // ALU operand side
  output logic [3:0]       alu_aluop,
  output logic [31:0]      alu_port_a,
  output logic [31:0]      alu_port_b,
  // ALU result side
  input  logic [31:0]      alu_port_output,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  input  logic             alu_negative,
  // writeback
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [31:0]      wb_data,
  output logic [4:0]       wb_rd,
  output logic [TAG_W-1:0] wb_tag,
  output logic             wb_overflow,
  output logic             wb_zero,
  output logic             wb_negative,
  // status
  output logic [15:0]      ovf_count,
  output logic             busy
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  // Operand stage
  logic             s1_valid_q, s1_valid_d;
  logic [3:0]       s1_op_q, s1_op_d;
  logic [31:0]      s1_a_q, s1_a_d;
  logic [31:0]      s1_b_q, s1_b_d;
  logic [4:0]       s1_rd_q, s1_rd_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  // Result FIFO; flags packed as {overflow, zero, negative}
  logic [31:0]      mem_data_q  [DEPTH];
  logic [2:0]       mem_flags_q [DEPTH];
  logic [4:0]       mem_rd_q    [DEPTH];
  logic [TAG_W-1:0] mem_tag_q   [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [15:0]      ovf_q, ovf_d;

  logic fifo_full;
  logic pop;
  logic s1_adv;
  logic accept;
  logic push;

  // Handshake decode; a pop frees a slot in the same cycle so a full FIFO still streams.
  always_comb begin
    fifo_full = (count_q == CntW'(DEPTH));
    wb_valid  = (count_q != '0);
    pop       = wb_valid && wb_ready;
    s1_adv    = s1_valid_q && (!fifo_full || pop);
    in_ready  = !s1_valid_q || s1_adv;
    accept    = in_valid && in_ready;
    push      = s1_adv && !flush;
    busy      = s1_valid_q || (count_q != '0);
  end

  // Operands go straight from S1 to the ALU; head of the FIFO drives writeback.
  always_comb begin
    alu_aluop   = s1_op_q;
    alu_port_a  = s1_a_q;
    alu_port_b  = s1_b_q;
    wb_data     = mem_data_q[rd_ptr_q];
    wb_overflow = mem_flags_q[rd_ptr_q][2];
    wb_zero     = mem_flags_q[rd_ptr_q][1];
    wb_negative = mem_flags_q[rd_ptr_q][0];
    wb_rd       = mem_rd_q[rd_ptr_q];
    wb_tag      = mem_tag_q[rd_ptr_q];
    ovf_count   = ovf_q;
  end

  // Next-state for operand stage, pointers, occupancy and overflow counter.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_rd_d    = s1_rd_q;
    s1_tag_d   = s1_tag_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;

    if (flush) begin
      // Squash everything; operand registers keep their contents for the ALU port.
      s1_valid_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (accept) begin
        s1_valid_d = 1'b1;
        s1_op_d    = in_aluop;
        s1_a_d     = in_a;
        s1_b_d     = in_b;
        s1_rd_d    = in_rd;
        s1_tag_d   = in_tag;
      end else if (s1_adv) begin
        s1_valid_d = 1'b0;
      end

      // DEPTH is a power of two, so pointer wrap is the natural PtrW-bit rollover.
      if (s1_adv) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + PtrW'(1);

      case ({s1_adv, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase

      if (pop && mem_flags_q[rd_ptr_q][2] && (ovf_q != 16'hFFFF)) begin
        ovf_d = ovf_q + 16'd1;
      end
    end
  end

  // Control and operand state with synchronous reset taking priority over flush.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_rd_q    <= '0;
      s1_tag_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_rd_q    <= s1_rd_d;
      s1_tag_q   <= s1_tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  // Result storage; entries only matter while counted, so no reset is needed.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_data_q[wr_ptr_q]  <= alu_port_output;
      mem_flags_q[wr_ptr_q] <= {alu_overflow, alu_zero, alu_negative};
      mem_rd_q[wr_ptr_q]    <= s1_rd_q;
      mem_tag_q[wr_ptr_q]   <= s1_tag_q;
    end
  end

endmodule
